ram_burst_sequencer: RTL

Burst sequencer that sits directly upstream of the configurable RAM wrapper and is its sole master. It accepts one burst request (base address, length, direction), then streams write beats into the RAM or read beats out of it, one word per cycle, honouring the RAM's `busy` stall. Cache line fill/writeback and DMA logic use it so they never drive the RAM strobes directly.

---
 rtl/ram_burst_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ram_burst_sequencer.sv
// Burst sequencer mastering a single-port RAM: one request in, a stream of
// write or read beats out, one word per cycle when the RAM is not busy.
module ram_burst_sequencer #(
  parameter int N_BYTES   = 4,
  parameter int DEPTH     = 256,
  parameter int MAX_BURST = 8,
  parameter int ADDR_BITS = $clog2(DEPTH),
  parameter int LEN_BITS  = $clog2(MAX_BURST),
  parameter int N_BITS    = N_BYTES * 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [LEN_BITS-1:0]  req_len,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [N_BITS-1:0]    wr_data,
  input  logic [N_BYTES-1:0]   wr_byte_en,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [N_BITS-1:0]    rd_data,
  output logic                 rd_last,
  output logic                 done,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [N_BITS-1:0]    ram_wdata,
  output logic [N_BYTES-1:0]   ram_byte_en,
  output logic                 ram_wen,
  output logic                 ram_ren,
  input  logic [N_BITS-1:0]    ram_rdata,
  input  logic                 ram_busy
);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_BITS-1:0]  cur_addr_reg, cur_addr_next;
  logic [LEN_BITS-1:0]   beats_left_reg, beats_left_next;
  logic                  rd_valid_reg, rd_valid_next;
  logic                  rd_last_reg, rd_last_next;
  logic [N_BITS-1:0]     rd_data_reg, rd_data_next;
  logic                  done_reg, done_next;
  logic                  accept;
  logic                  last_beat;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      cur_addr_reg   <= '0;
      beats_left_reg <= '0;
      rd_valid_reg   <= 1'b0;
      rd_last_reg    <= 1'b0;
      rd_data_reg    <= '0;
      done_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cur_addr_reg   <= cur_addr_next;
      beats_left_reg <= beats_left_next;
      rd_valid_reg   <= rd_valid_next;
      rd_last_reg    <= rd_last_next;
      rd_data_reg    <= rd_data_next;
      done_reg       <= done_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    cur_addr_next   = cur_addr_reg;
    beats_left_next = beats_left_reg;
    rd_valid_next   = rd_valid_reg;
    rd_last_next    = rd_last_reg;
    rd_data_next    = rd_data_reg;
    done_next       = 1'b0;
    req_ready       = 1'b0;
    wr_ready        = 1'b0;
    ram_wen         = 1'b0;
    ram_ren         = 1'b0;
    accept          = 1'b0;
    last_beat       = (beats_left_reg == '0);

    case (state_reg)
      IDLE: begin
        req_ready = !RST;
        if (req_valid) begin
          cur_addr_next   = req_addr;
          beats_left_next = req_len;
          state_next      = req_write ? WR : RD;
        end
      end

      WR: begin
        // Strobes are held low during reset so an aborted burst writes nothing more.
        ram_wen  = wr_valid && !RST;
        wr_ready = ram_wen && !ram_busy;
        accept   = wr_ready;
        if (accept) begin
          cur_addr_next   = cur_addr_reg + ADDR_BITS'(1);
          beats_left_next = beats_left_reg - LEN_BITS'(1);
          if (last_beat) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end

      RD: begin
        // Fetch only when the holding register is empty or being emptied this cycle.
        ram_ren = (!rd_valid_reg || rd_ready) && !RST;
        accept  = ram_ren && !ram_busy;
        if (accept) begin
          rd_data_next    = ram_rdata;
          rd_valid_next   = 1'b1;
          rd_last_next    = last_beat;
          cur_addr_next   = cur_addr_reg + ADDR_BITS'(1);
          beats_left_next = beats_left_reg - LEN_BITS'(1);
          if (last_beat) state_next = DRAIN;
        end else if (rd_ready) begin
          rd_valid_next = 1'b0;
          rd_last_next  = 1'b0;
        end
      end

      DRAIN: begin
        if (rd_valid_reg && rd_ready && rd_last_reg) begin
          state_next    = IDLE;
          rd_valid_next = 1'b0;
          rd_last_next  = 1'b0;
          done_next     = 1'b1;
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign ram_addr    = cur_addr_reg;
  assign ram_wdata   = wr_data;
  assign ram_byte_en = wr_byte_en;
  assign rd_valid    = rd_valid_reg;
  assign rd_last     = rd_last_reg;
  assign rd_data     = rd_data_reg;
  assign done        = done_reg;

endmodule
